warp_scanseq: RTL and testbench
===============================

// Module: warp_scanseq
// PURPOSE
//  Frame scan sequencer at the head of the warp pipeline. On start it walks every
//  destination pixel of an hres x vres frame in raster order. For each pixel it
//  presents td_x/td_y and the source coordinate ts = td + (dx,dy) through a
//  ready/next handshake. The downstream boundary check drops out-of-frame points,
//  so no clipping is done here.
// PARAMETERS
//  none (coordinate width fixed at 11 bits, matching the warp datapath)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   reset, synchronous, active-high
//  start     in   1   begin a frame scan; honoured only in IDLE
//  hres      in   11  frame width in pixels; sampled on accepted start
//  vres      in   11  frame height in pixels; sampled on accepted start
//  dx        in   11  signed X offset, source minus destination; sampled on start
//  dy        in   11  signed Y offset; sampled on start
//  td_x      out  11  destination X of the presented point
//  td_y      out  11  destination Y of the presented point
//  ts_x      out  11  source X = td_x + dx, modulo 2^11
//  ts_y      out  11  source Y = td_y + dy, modulo 2^11
//  t_ready   out  1   point on td/ts is valid
//  t_next    in   1   consumer takes the point this cycle if t_ready=1
//  busy      out  1   scan in progress (state != IDLE)
//  done      out  1   one-cycle pulse: last point of frame accepted
//  abort     in   1   only with WARP_SCANSEQ_ABORT_EN; see CONFIGURATION
// BEHAVIOUR
//  - All outputs registered. Reset: td_*=0, ts_*=0, t_ready=0, busy=0, done=0,
//    state=IDLE, latched hres/vres/dx/dy=0.
//  - States: IDLE, RUN.
//    IDLE: on start=1, latch hres/vres/dx/dy.
//      hres==0 or vres==0: stay IDLE, done=1 next cycle, no points issued.
//      Otherwise go RUN next cycle with td=(0,0), ts=(dx,dy), t_ready=1, busy=1.
//    RUN: start ignored. Input changes after the start cycle have no effect.
//  - Handshake: transfer when t_ready & t_next. Outputs hold stable while
//    t_ready=1 & t_next=0. After a transfer the next point is on the outputs the
//    following cycle with t_ready still 1. Sustained throughput: 1 point/clock.
//  - Advance: x<hres-1 -> x+1; else x=0, y+1. Every advance recomputes ts.
//  - Last point (x==hres-1 & y==vres-1) accepted: t_ready=0, busy=0, done=1 for
//    one cycle, state=IDLE. A start in the done cycle is honoured, which allows
//    back-to-back frames with one idle cycle.
//  - Arithmetic: 11-bit two's-complement add; carry discarded. Negative or
//    overflowing ts wraps to a large unsigned value and is rejected downstream.
//  - Point count per frame = hres*vres exactly; no duplicates, no skips.
//  - Reset asserted mid-scan: next-cycle state equals the reset values; the
//    in-flight point is discarded.
// CONFIGURATION
//  - WARP_SCANSEQ_ABORT_EN defined: abort port exists.
//    abort=1 in RUN: next cycle IDLE, t_ready=0, busy=0, done=0.
//    Abort wins over a simultaneous transfer; that point counts as not issued.
//    abort in IDLE has no effect.
//  - Not defined: no abort port; a scan always runs to completion or reset.
// TESTING
//  1. hres=4,vres=2,dx=0,dy=0,t_next=1 always -> 8 points (0,0)..(3,1) on 8
//     consecutive clocks; done pulses once on the cycle after (3,1); busy=0 after.
//  2. hres=3,vres=1,dx=-1(0x7FF),dy=2 -> ts=(0x7FF,2),(0,2),(1,2).
//  3. hres=3,vres=2,t_next toggling 1/0 -> each point held while t_next=0; still
//     exactly 6 points in order; done after 6th transfer.
//  4. hres=0,vres=5,start -> no t_ready, done=1 one cycle later; start during RUN
//     with new hres ignored.
//  5. rst in cycle 3 of a 4x4 scan -> all outputs at reset values next cycle;
//     new start scans from (0,0).
//  6. (ABORT_EN) abort with t_next=1 at point (2,0) of 4x2 -> t_ready=0,
//     busy=0 next cycle, done never asserted.

Source files
------------

// File: rtl/warp_scanseq.sv
// Frame scan sequencer: walks an hres x vres frame in raster order and presents
// destination/source coordinates through a ready/next handshake. WARP_SCANSEQ_ABORT_EN adds abort.
module warp_scanseq (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [10:0] hres_i,
   input  logic [10:0] vres_i,
   input  logic [10:0] dx_i,
   input  logic [10:0] dy_i,
   output logic [10:0] td_x_o,
   output logic [10:0] td_y_o,
   output logic [10:0] ts_x_o,
   output logic [10:0] ts_y_o,
   output logic        t_ready_o,
   input  logic        t_next_i,
`ifdef WARP_SCANSEQ_ABORT_EN
   input  logic        abort_i,
`endif
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic [10:0] hres_q, hres_d;
   logic [10:0] vres_q, vres_d;
   logic [10:0] dx_q, dx_d;
   logic [10:0] dy_q, dy_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [10:0] ts_x_q, ts_x_d;
   logic [10:0] ts_y_q, ts_y_d;
   logic        done_q, done_d;

   logic        abort_w;
   logic        x_last, y_last;
   logic [10:0] x_adv, y_adv;

`ifdef WARP_SCANSEQ_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   assign x_last = (x_q == hres_q - 11'd1);
   assign y_last = (y_q == vres_q - 11'd1);

   always_comb begin
      state_d = state_q;
      hres_d  = hres_q;
      vres_d  = vres_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      x_d     = x_q;
      y_d     = y_q;
      ts_x_d  = ts_x_q;
      ts_y_d  = ts_y_q;
      done_d  = 1'b0;

      if (x_last) begin
         x_adv = 11'd0;
         y_adv = y_q + 11'd1;
      end else begin
         x_adv = x_q + 11'd1;
         y_adv = y_q;
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               hres_d = hres_i;
               vres_d = vres_i;
               dx_d   = dx_i;
               dy_d   = dy_i;
               if ((hres_i == 11'd0) || (vres_i == 11'd0)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = StRun;
                  x_d     = 11'd0;
                  y_d     = 11'd0;
                  ts_x_d  = dx_i;
                  ts_y_d  = dy_i;
               end
            end
         end
         StRun: begin
            // Abort takes priority over a simultaneous transfer.
            if (abort_w) begin
               state_d = StIdle;
            end else if (t_next_i) begin
               if (x_last && y_last) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  x_d    = x_adv;
                  y_d    = y_adv;
                  ts_x_d = x_adv + dx_q;
                  ts_y_d = y_adv + dy_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         hres_q  <= '0;
         vres_q  <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         ts_x_q  <= '0;
         ts_y_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hres_q  <= hres_d;
         vres_q  <= vres_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ts_x_q  <= ts_x_d;
         ts_y_q  <= ts_y_d;
         done_q  <= done_d;
      end
   end

   assign td_x_o    = x_q;
   assign td_y_o    = y_q;
   assign ts_x_o    = ts_x_q;
   assign ts_y_o    = ts_y_q;
   assign t_ready_o = (state_q == StRun);
   assign busy_o    = (state_q == StRun);
   assign done_o    = done_q;

endmodule

// File: tb/tb_warp_scanseq.sv
// Scoreboard bench for warp_scanseq: stimulus pushes expected points, a negedge
// monitor pops and compares on every handshake transfer.
module tb_warp_scanseq;

   logic        clk = 1'b0;
   logic        rst, start, t_next, abort;
   logic [10:0] hres, vres, dx, dy;
   logic [10:0] td_x, td_y, ts_x, ts_y;
   logic        t_ready, busy, done;

   always #5 clk = ~clk;

   warp_scanseq dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .hres_i    (hres),
      .vres_i    (vres),
      .dx_i      (dx),
      .dy_i      (dy),
      .td_x_o    (td_x),
      .td_y_o    (td_y),
      .ts_x_o    (ts_x),
      .ts_y_o    (ts_y),
      .t_ready_o (t_ready),
      .t_next_i  (t_next),
`ifdef WARP_SCANSEQ_ABORT_EN
      .abort_i   (abort),
`endif
      .busy_o    (busy),
      .done_o    (done)
   );

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic [10:0] sx;
      logic [10:0] sy;
   } pt_t;

   pt_t exp_q[$];
   int  vec_cnt = 0;
   int  err_cnt = 0;
   int  cyc = 0;
   int  done_cnt = 0;
   int  first_xfer = -1;
   int  last_xfer = -1;
   int  done_cyc = -1;
   int  done_base;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int x, input int y, input int sx, input int sy);
      pt_t p;
      p.x  = 11'(x);
      p.y  = 11'(y);
      p.sx = 11'(sx);
      p.sy = 11'(sy);
      exp_q.push_back(p);
   endtask

   task automatic do_start(input int h, input int v, input int ox, input int oy);
      @(posedge clk);
      #1;
      start = 1'b1;
      hres  = 11'(h);
      vres  = 11'(v);
      dx    = 11'(ox);
      dy    = 11'(oy);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cyc = cyc;
            return;
         end
      end
      vec_cnt++;
      err_cnt++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done pulse", max_cyc);
   endtask

   // Monitor: pops the scoreboard on each transfer and checks hold stability.
   logic prev_hold = 1'b0;
   pt_t  prev_pt;
   pt_t  cur_pt;
   pt_t  exp_pt;
   always @(negedge clk) begin
      cur_pt = {td_x, td_y, ts_x, ts_y};
      if (prev_hold) check("hold_stable", 64'(cur_pt), 64'(prev_pt));
      if (done === 1'b1) done_cnt++;
      if (t_ready === 1'b1 && t_next === 1'b1 && abort !== 1'b1) begin
         if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_point: got %0h expected no point", cur_pt);
         end else begin
            exp_pt = exp_q.pop_front();
            check("point", 64'(cur_pt), 64'(exp_pt));
         end
         if (first_xfer < 0) first_xfer = cyc;
         last_xfer = cyc;
      end
      prev_hold = (t_ready === 1'b1) && !t_next && !rst && !abort;
      prev_pt   = cur_pt;
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      t_next = 1'b0;
      abort  = 1'b0;
      hres   = '0;
      vres   = '0;
      dx     = '0;
      dy     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 64'({td_x, td_y, ts_x, ts_y, t_ready, busy, done}), 64'd0);
      rst = 1'b0;

      // 1: 4x2, zero offset, continuous consumer
      t_next = 1'b1;
      push(0, 0, 0, 0); push(1, 0, 1, 0); push(2, 0, 2, 0); push(3, 0, 3, 0);
      push(0, 1, 0, 1); push(1, 1, 1, 1); push(2, 1, 2, 1); push(3, 1, 3, 1);
      first_xfer = -1;
      done_base  = done_cnt;
      do_start(4, 2, 0, 0);
      wait_done(40);
      check("t1_throughput_span", 64'(last_xfer - first_xfer), 64'd7);
      check("t1_done_latency", 64'(done_cyc - last_xfer), 64'd1);
      @(negedge clk);
      check("t1_done_once", 64'(done_cnt - done_base), 64'd1);
      check("t1_idle_after", 64'({busy, t_ready, done}), 64'd0);
      check("t1_all_points", 64'(exp_q.size()), 64'd0);

      // 2: negative dx wraps
      push(0, 0, 11'h7FF, 2); push(1, 0, 0, 2); push(2, 0, 1, 2);
      do_start(3, 1, 11'h7FF, 2);
      wait_done(40);
      @(negedge clk);
      check("t2_all_points", 64'(exp_q.size()), 64'd0);
      check("t2_busy_after", 64'(busy), 64'd0);

      // 3: consumer toggling next every cycle
      t_next = 1'b0;
      push(0, 0, 0, 0); push(1, 0, 1, 0); push(2, 0, 2, 0);
      push(0, 1, 0, 1); push(1, 1, 1, 1); push(2, 1, 2, 1);
      done_base = done_cnt;
      do_start(3, 2, 0, 0);
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) break;
         t_next = ~t_next;
      end
      check("t3_done_seen", 64'(done), 64'd1);
      t_next = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t3_all_points", 64'(exp_q.size()), 64'd0);
      check("t3_done_once", 64'(done_cnt - done_base), 64'd1);

      // 4: zero-size frame, then start ignored during a run
      do_start(0, 5, 0, 0);
      @(negedge clk);
      check("t4_empty_done", 64'({done, t_ready, busy}), 64'b100);
      @(negedge clk);
      check("t4_done_pulse", 64'({done, t_ready}), 64'd0);
      push(0, 0, 3, 4); push(1, 0, 4, 4);
      do_start(2, 1, 3, 4);
      @(posedge clk);
      #1;
      start = 1'b1;
      hres  = 11'd7;
      vres  = 11'd7;
      dx    = 11'd9;
      @(posedge clk);
      #1;
      start  = 1'b0;
      t_next = 1'b1;
      wait_done(40);
      @(negedge clk);
      check("t4_ignored_start", 64'(exp_q.size()), 64'd0);
      check("t4_idle_after", 64'(busy), 64'd0);

      // 5: reset during a 4x4 scan
      push(0, 0, 0, 0); push(1, 0, 1, 0);
      do_start(4, 4, 0, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst    = 1'b1;
      t_next = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t5_reset_outputs", 64'({td_x, td_y, ts_x, ts_y, t_ready, busy, done}), 64'd0);
      check("t5_points_before_rst", 64'(exp_q.size()), 64'd0);
      rst    = 1'b0;
      t_next = 1'b1;
      push(0, 0, 1, 1); push(1, 0, 2, 1); push(0, 1, 1, 2); push(1, 1, 2, 2);
      do_start(2, 2, 1, 1);
      wait_done(40);
      @(negedge clk);
      check("t5_restart_points", 64'(exp_q.size()), 64'd0);

`ifdef WARP_SCANSEQ_ABORT_EN
      // 6: abort at (2,0) with a simultaneous transfer
      push(0, 0, 0, 0); push(1, 0, 1, 0);
      done_base = done_cnt;
      do_start(4, 2, 0, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("t6_abort_point", 64'({td_x, td_y}), 64'({11'd2, 11'd0}));
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check("t6_abort_idle", 64'({t_ready, busy, done}), 64'd0);
      repeat (5) @(negedge clk);
      check("t6_no_done", 64'(done_cnt - done_base), 64'd0);
      check("t6_points", 64'(exp_q.size()), 64'd0);
`endif

      t_next = 1'b0;
      repeat (2) @(negedge clk);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish before 200000");
      $fatal(1);
   end

endmodule
